// File: rtl/upsample_pulse_shaper_pkg.sv
// Shared widths, RRC coefficient set and mapping/saturation helpers for the
// 64QAM upsampling pulse shaper.
package upsample_pkg;

   localparam int unsigned NUM_TAPS_DEF = 16;
   localparam int unsigned COEF_W_DEF   = 10;
   localparam int unsigned ACC_W        = 18;
   localparam int unsigned SYM_W        = 3;
   localparam int unsigned LVL_W        = 4;
   localparam int unsigned OUT_W        = 12;
   localparam int unsigned RATE_W       = 9;

   typedef logic signed [LVL_W-1:0] level_t;
   typedef logic signed [ACC_W-1:0] acc_t;
   typedef logic signed [OUT_W-1:0] sample_t;

   // Kind of sample produced on a given cycle
   typedef enum logic [1:0] {
      SLOT_IDLE,
      SLOT_SYMBOL,
      SLOT_STUFF
   } slot_e;

   // Stage-1 tag travelling alongside the delay-line shift
   typedef struct packed {
      logic              valid;
      logic [RATE_W-1:0] index;
   } tag_t;

   // Symmetric root-raised-cosine taps, peak at the centre pair
   localparam logic signed [COEF_W_DEF-1:0] H [NUM_TAPS_DEF] = '{
      -10'sd4,  -10'sd10, -10'sd8,  10'sd12,
       10'sd58,  10'sd156, 10'sd312, 10'sd511,
       10'sd511, 10'sd312, 10'sd156, 10'sd58,
       10'sd12, -10'sd8,  -10'sd10, -10'sd4
   };

   function automatic level_t gray_to_level(input logic [SYM_W-1:0] g);
      level_t lvl;
      case (g)
         3'b000:  lvl = -4'sd7;
         3'b001:  lvl = -4'sd5;
         3'b011:  lvl = -4'sd3;
         3'b010:  lvl = -4'sd1;
         3'b110:  lvl =  4'sd1;
         3'b111:  lvl =  4'sd3;
         3'b101:  lvl =  4'sd5;
         default: lvl =  4'sd7;
      endcase
      return lvl;
   endfunction

   function automatic sample_t sat12(input acc_t acc);
      sample_t res;
      if (acc > ACC_W'(2047))
         res = OUT_W'(2047);
      else if (acc < ACC_W'(-2048))
         res = OUT_W'(-2048);
      else
         res = OUT_W'(acc);
      return res;
   endfunction

endpackage

// File: rtl/upsample_pulse_shaper_if.sv
// Symbol handshake and filtered-sample bus of the upsampling pulse shaper.
interface upsample_pulse_shaper_if;
   import upsample_pkg::*;

   logic             sym_valid;
   logic             sym_ready;
   logic [SYM_W-1:0] sym_i;
   logic [SYM_W-1:0] sym_q;

   sample_t           I_filter;
   sample_t           Q_filter;
   logic              valid_data;
   logic [RATE_W-1:0] sample_index;

   modport master (
      output sym_valid, sym_i, sym_q,
      input  sym_ready, I_filter, Q_filter, valid_data, sample_index
   );

   modport slave (
      input  sym_valid, sym_i, sym_q,
      output sym_ready, I_filter, Q_filter, valid_data, sample_index
   );
endinterface

// File: rtl/upsample_pulse_shaper_fir_channel.sv
// One pulse-shaping FIR channel: level delay line, MAC and saturating
// output register.
module fir_channel
   import upsample_pkg::*;
#(
   parameter int unsigned NUM_TAPS = NUM_TAPS_DEF,
   parameter int unsigned COEF_W   = COEF_W_DEF,
   parameter int unsigned SHIFT    = 4
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    shift_en,
   input  logic    load_en,
   input  level_t  din,
   output sample_t dout
);

   level_t dl [NUM_TAPS];
   acc_t   acc_c;

   // Taps beyond the shared set contribute nothing
   function automatic logic signed [COEF_W-1:0] coef(input int k);
      logic signed [COEF_W-1:0] c;
      c = '0;
      if (k < int'(NUM_TAPS_DEF))
         c = COEF_W'(H[k]);
      return c;
   endfunction

   always_comb begin
      acc_c = '0;
      for (int k = 0; k < int'(NUM_TAPS); k++)
         acc_c = acc_c + ACC_W'(dl[k]) * ACC_W'(coef(k));
   end

   // dl[0] holds the newest sample; the output only moves on a fresh sample
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int k = 0; k < int'(NUM_TAPS); k++)
            dl[k] <= '0;
         dout <= '0;
      end else begin
         if (shift_en) begin
            dl[0] <= din;
            for (int k = 1; k < int'(NUM_TAPS); k++)
               dl[k] <= dl[k-1];
         end
         if (load_en)
            dout <= sat12(acc_c >>> SHIFT);
      end
   end

endmodule

// File: rtl/upsample_pulse_shaper.sv
// 64QAM symbol intake, runtime zero-stuffing and dual-rail RRC pulse
// shaping; one output sample per clk while symbols keep arriving.
module upsample_pulse_shaper
   import upsample_pkg::*;
#(
   parameter int unsigned NUM_TAPS = NUM_TAPS_DEF,
   parameter int unsigned COEF_W   = COEF_W_DEF,
   parameter int unsigned SHIFT    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [RATE_W-1:0]   upsampling_rate,
   upsample_pulse_shaper_if.slave bus
);

   logic [RATE_W-1:0] phase, phase_d;
   logic [RATE_W-1:0] rate_l, rate_d;
   logic [RATE_W-1:0] rate_req_c;
   tag_t              s1, s1_d;
   slot_e             slot_c;
   logic              shift_c;
   level_t            lvl_i_c, lvl_q_c;
   logic              valid_data;
   logic [RATE_W-1:0] sample_index;

   assign bus.sym_ready = rst && enable && (phase == '0);

   // Decide this cycle's sample and advance the symbol phase
   always_comb begin
      rate_req_c = (upsampling_rate == '0) ? RATE_W'(1) : upsampling_rate;
      slot_c     = SLOT_IDLE;
      phase_d    = phase;
      rate_d     = rate_l;
      s1_d       = s1;
      s1_d.valid = 1'b0;

      if (enable) begin
         if (phase != '0)
            slot_c = SLOT_STUFF;
         else if (bus.sym_valid)
            slot_c = SLOT_SYMBOL;
      end

      case (slot_c)
         SLOT_SYMBOL: begin
            rate_d     = rate_req_c;
            phase_d    = rate_req_c - RATE_W'(1);
            s1_d.valid = 1'b1;
            s1_d.index = '0;
         end
         SLOT_STUFF: begin
            phase_d    = phase - RATE_W'(1);
            s1_d.valid = 1'b1;
            s1_d.index = rate_l - phase;
         end
         default: ;
      endcase
   end

   assign shift_c = (slot_c != SLOT_IDLE);
   assign lvl_i_c = (slot_c == SLOT_SYMBOL) ? gray_to_level(bus.sym_i) : '0;
   assign lvl_q_c = (slot_c == SLOT_SYMBOL) ? gray_to_level(bus.sym_q) : '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         phase        <= '0;
         rate_l       <= '0;
         s1           <= '0;
         valid_data   <= 1'b0;
         sample_index <= '0;
      end else begin
         phase      <= phase_d;
         rate_l     <= rate_d;
         s1         <= s1_d;
         valid_data <= s1.valid;
         if (s1.valid)
            sample_index <= s1.index;
      end
   end

   assign bus.valid_data   = valid_data;
   assign bus.sample_index = sample_index;

   fir_channel #(
      .NUM_TAPS (NUM_TAPS),
      .COEF_W   (COEF_W),
      .SHIFT    (SHIFT)
   ) u_fir_i (
      .clk      (clk),
      .rst      (rst),
      .shift_en (shift_c),
      .load_en  (s1.valid),
      .din      (lvl_i_c),
      .dout     (bus.I_filter)
   );

   fir_channel #(
      .NUM_TAPS (NUM_TAPS),
      .COEF_W   (COEF_W),
      .SHIFT    (SHIFT)
   ) u_fir_q (
      .clk      (clk),
      .rst      (rst),
      .shift_en (shift_c),
      .load_en  (s1.valid),
      .din      (lvl_q_c),
      .dout     (bus.Q_filter)
   );

endmodule

// File: tb/tb_upsample_pulse_shaper.sv
// Directed bench for upsample_pulse_shaper: reset, impulse, streaming,
// saturation, rate/enable edge cases and mid-symbol reset.
module tb_upsample_pulse_shaper;

   localparam int H_TB [16] = '{-4, -10, -8, 12, 58, 156, 312, 511,
                                511, 312, 156, 58, 12, -8, -10, -4};

   logic       clk;
   logic       rst;
   logic       enable;
   logic [8:0] rate;

   int checks   = 0;
   int failures = 0;
   int x_i [64];
   int x_q [64];

   upsample_pulse_shaper_if bus ();
   upsample_pulse_shaper_if bus_s ();

   upsample_pulse_shaper #(.NUM_TAPS(16), .COEF_W(10), .SHIFT(4)) dut (
      .clk(clk), .rst(rst), .enable(enable), .upsampling_rate(rate), .bus(bus)
   );

   upsample_pulse_shaper #(.NUM_TAPS(16), .COEF_W(10), .SHIFT(0)) dut_sat (
      .clk(clk), .rst(rst), .enable(enable), .upsampling_rate(rate), .bus(bus_s)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int gray_lvl(input logic [2:0] g);
      case (g)
         3'b000: return -7;
         3'b001: return -5;
         3'b011: return -3;
         3'b010: return -1;
         3'b110: return 1;
         3'b111: return 3;
         3'b101: return 5;
         default: return 7;
      endcase
   endfunction

   // Convolution of the zero-stuffed sample stream, then shift and clamp
   function automatic int golden(input int x [64], input int n, input int sh);
      int acc = 0;
      for (int k = 0; k < 16; k++)
         if (n - k >= 0) acc += H_TB[k] * x[n-k];
      acc = acc >>> sh;
      if (acc > 2047) acc = 2047;
      else if (acc < -2048) acc = -2048;
      return acc;
   endfunction

   task automatic clear_x();
      for (int j = 0; j < 64; j++) begin
         x_i[j] = 0;
         x_q[j] = 0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      enable = 1'b1;
      bus.sym_valid = 1'b0;
      bus_s.sym_valid = 1'b0;
      repeat (2) step();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; enable = 1'b1; rate = 9'd4;
      bus.sym_valid = 1'b1; bus.sym_i = 3'b100; bus.sym_q = 3'b100;
      bus_s.sym_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if (bus.sym_ready !== 1'b0) begin
            failures++; $display("FAIL reset_ready c=%0d got=%b exp=0", c, bus.sym_ready);
         end
         checks++;
         if (bus.valid_data !== 1'b0 || bus.I_filter !== 12'd0 || bus.Q_filter !== 12'd0 || bus.sample_index !== 9'd0) begin
            failures++;
            $display("FAIL reset_outputs c=%0d got v=%b i=%0d q=%0d idx=%0d exp all 0",
                     c, bus.valid_data, bus.I_filter, bus.Q_filter, bus.sample_index);
         end
         checks++;
         if (bus_s.valid_data !== 1'b0 || bus_s.I_filter !== 12'd0 || bus_s.Q_filter !== 12'd0) begin
            failures++;
            $display("FAIL reset_outputs_sat c=%0d got v=%b i=%0d q=%0d exp all 0",
                     c, bus_s.valid_data, bus_s.I_filter, bus_s.Q_filter);
         end
      end
      bus.sym_valid = 1'b0; bus_s.sym_valid = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.sym_ready !== 1'b1) begin
         failures++; $display("FAIL reset_release_ready got=%b exp=1", bus.sym_ready);
      end
   endtask

   task automatic test_impulse();
      int imp_i [4] = '{-2, -5, -4, 5};
      int imp_q [4] = '{1, 4, 3, -6};
      do_reset();
      rate = 9'd4;
      bus.sym_valid = 1'b1; bus.sym_i = 3'b100; bus.sym_q = 3'b000;
      #1;
      checks++;
      if (bus.sym_ready !== 1'b1) begin
         failures++; $display("FAIL impulse_ready0 got=%b exp=1", bus.sym_ready);
      end
      step();
      bus.sym_valid = 1'b0; bus.sym_i = 3'b010;
      checks++;
      if (bus.valid_data !== 1'b0 || bus.sym_ready !== 1'b0) begin
         failures++; $display("FAIL impulse_first_edge got v=%b rdy=%b exp v=0 rdy=0", bus.valid_data, bus.sym_ready);
      end
      for (int k = 1; k <= 8; k++) begin
         step();
         checks++;
         if (bus.valid_data !== (k <= 4)) begin
            failures++; $display("FAIL impulse_valid k=%0d got=%b exp=%b", k, bus.valid_data, (k <= 4));
         end
         checks++;
         if (bus.sym_ready !== (k >= 3)) begin
            failures++; $display("FAIL impulse_ready k=%0d got=%b exp=%b", k, bus.sym_ready, (k >= 3));
         end
         if (k <= 4) begin
            checks++;
            if (bus.I_filter !== 12'(imp_i[k-1]) || bus.Q_filter !== 12'(imp_q[k-1]) || bus.sample_index !== 9'(k-1)) begin
               failures++;
               $display("FAIL impulse_sample k=%0d got i=%0d q=%0d idx=%0d exp i=%0d q=%0d idx=%0d",
                        k, bus.I_filter, bus.Q_filter, bus.sample_index, imp_i[k-1], imp_q[k-1], k-1);
            end
         end else begin
            checks++;
            if (bus.I_filter !== 12'd5 || bus.Q_filter !== 12'(-6)) begin
               failures++; $display("FAIL impulse_hold k=%0d got i=%0d q=%0d exp i=5 q=-6", k, bus.I_filter, bus.Q_filter);
            end
         end
      end
   endtask

   task automatic test_stream();
      logic [2:0] si [10] = '{3'b100, 3'b000, 3'b110, 3'b011, 3'b111, 3'b010, 3'b101, 3'b001, 3'b100, 3'b100};
      logic [2:0] sq [10] = '{3'b000, 3'b100, 3'b001, 3'b111, 3'b010, 3'b011, 3'b110, 3'b101, 3'b000, 3'b111};
      int ptr = 0;
      int nout = 0;
      do_reset();
      clear_x();
      for (int j = 0; j < 10; j++) begin
         x_i[2*j] = gray_lvl(si[j]);
         x_q[2*j] = gray_lvl(sq[j]);
      end
      rate = 9'd2;
      for (int c = 0; c < 30; c++) begin
         bus.sym_valid = (ptr < 10);
         bus.sym_i = si[ptr % 10];
         bus.sym_q = sq[ptr % 10];
         #1;
         if (ptr < 10) begin
            checks++;
            if (bus.sym_ready !== (c % 2 == 0)) begin
               failures++; $display("FAIL stream_ready c=%0d got=%b exp=%b", c, bus.sym_ready, (c % 2 == 0));
            end
         end
         if (bus.sym_valid && bus.sym_ready) ptr++;
         step();
         checks++;
         if (bus.valid_data !== (c >= 1 && c <= 20)) begin
            failures++; $display("FAIL stream_valid c=%0d got=%b exp=%b", c, bus.valid_data, (c >= 1 && c <= 20));
         end
         if (bus.valid_data === 1'b1) begin
            checks++;
            if (bus.I_filter !== 12'(golden(x_i, nout, 4)) || bus.Q_filter !== 12'(golden(x_q, nout, 4)) ||
                bus.sample_index !== 9'(nout % 2)) begin
               failures++;
               $display("FAIL stream_sample n=%0d got i=%0d q=%0d idx=%0d exp i=%0d q=%0d idx=%0d",
                        nout, bus.I_filter, bus.Q_filter, bus.sample_index,
                        golden(x_i, nout, 4), golden(x_q, nout, 4), nout % 2);
            end
            nout++;
         end
      end
      checks++;
      if (nout != 20) begin
         failures++; $display("FAIL stream_count got=%0d exp=20", nout);
      end
   endtask

   task automatic test_saturation();
      int cnt = 0;
      int nout = 0;
      do_reset();
      clear_x();
      for (int j = 0; j < 16; j++) begin
         x_i[j] = 7;
         x_q[j] = -7;
      end
      rate = 9'd1;
      bus_s.sym_i = 3'b100; bus_s.sym_q = 3'b000;
      for (int c = 0; c < 20; c++) begin
         bus_s.sym_valid = (cnt < 16);
         #1;
         if (bus_s.sym_valid && bus_s.sym_ready) cnt++;
         step();
         if (bus_s.valid_data === 1'b1) begin
            checks++;
            if (bus_s.I_filter !== 12'(golden(x_i, nout, 0)) || bus_s.Q_filter !== 12'(golden(x_q, nout, 0)) ||
                bus_s.sample_index !== 9'd0) begin
               failures++;
               $display("FAIL sat_sample n=%0d got i=%0d q=%0d idx=%0d exp i=%0d q=%0d idx=0",
                        nout, bus_s.I_filter, bus_s.Q_filter, bus_s.sample_index,
                        golden(x_i, nout, 0), golden(x_q, nout, 0));
            end
            nout++;
         end
      end
      bus_s.sym_valid = 1'b0;
      checks++;
      if (nout != 16) begin
         failures++; $display("FAIL sat_count got=%0d exp=16", nout);
      end
      checks++;
      if (bus_s.I_filter !== 12'd2047 || bus_s.Q_filter !== 12'(-2048)) begin
         failures++; $display("FAIL sat_clamp got i=%0d q=%0d exp i=2047 q=-2048", bus_s.I_filter, bus_s.Q_filter);
      end
   endtask

   task automatic test_rate_edges();
      logic [2:0] r0_i [3] = '{3'b001, 3'b110, 3'b101};
      logic [2:0] r0_q [3] = '{3'b111, 3'b010, 3'b100};
      logic [2:0] ab_i [2] = '{3'b100, 3'b000};
      logic [2:0] ab_q [2] = '{3'b011, 3'b111};
      logic [2:0] en_i [2] = '{3'b111, 3'b001};
      logic [2:0] en_q [2] = '{3'b010, 3'b110};
      int idx_rc [8] = '{0, 1, 2, 0, 1, 2, 3, 4};
      int idx_en [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      logic [11:0] vmask = 12'b0111_1110_0110;
      int ptr, nout;

      // Rate 0 behaves as rate 1
      do_reset();
      clear_x();
      for (int j = 0; j < 3; j++) begin
         x_i[j] = gray_lvl(r0_i[j]);
         x_q[j] = gray_lvl(r0_q[j]);
      end
      rate = 9'd0; ptr = 0; nout = 0;
      for (int c = 0; c < 6; c++) begin
         bus.sym_valid = (ptr < 3);
         bus.sym_i = r0_i[ptr % 3]; bus.sym_q = r0_q[ptr % 3];
         #1;
         if (ptr < 3) begin
            checks++;
            if (bus.sym_ready !== 1'b1) begin
               failures++; $display("FAIL rate0_ready c=%0d got=%b exp=1", c, bus.sym_ready);
            end
         end
         if (bus.sym_valid && bus.sym_ready) ptr++;
         step();
         if (bus.valid_data === 1'b1) begin
            checks++;
            if (bus.I_filter !== 12'(golden(x_i, nout, 4)) || bus.Q_filter !== 12'(golden(x_q, nout, 4)) ||
                bus.sample_index !== 9'd0) begin
               failures++;
               $display("FAIL rate0_sample n=%0d got i=%0d q=%0d idx=%0d exp i=%0d q=%0d idx=0",
                        nout, bus.I_filter, bus.Q_filter, bus.sample_index, golden(x_i, nout, 4), golden(x_q, nout, 4));
            end
            nout++;
         end
      end
      checks++;
      if (nout != 3) begin
         failures++; $display("FAIL rate0_count got=%0d exp=3", nout);
      end

      // Rate change 3 -> 5 while the first symbol sits at phase 1
      do_reset();
      clear_x();
      x_i[0] = gray_lvl(ab_i[0]); x_q[0] = gray_lvl(ab_q[0]);
      x_i[3] = gray_lvl(ab_i[1]); x_q[3] = gray_lvl(ab_q[1]);
      ptr = 0; nout = 0;
      for (int c = 0; c < 12; c++) begin
         rate = (c < 2) ? 9'd3 : 9'd5;
         bus.sym_valid = (ptr < 2);
         bus.sym_i = ab_i[ptr % 2]; bus.sym_q = ab_q[ptr % 2];
         #1;
         if (bus.sym_valid && bus.sym_ready) ptr++;
         step();
         if (bus.valid_data === 1'b1 && nout < 8) begin
            checks++;
            if (bus.I_filter !== 12'(golden(x_i, nout, 4)) || bus.Q_filter !== 12'(golden(x_q, nout, 4)) ||
                bus.sample_index !== 9'(idx_rc[nout])) begin
               failures++;
               $display("FAIL ratechg_sample n=%0d got i=%0d q=%0d idx=%0d exp i=%0d q=%0d idx=%0d",
                        nout, bus.I_filter, bus.Q_filter, bus.sample_index,
                        golden(x_i, nout, 4), golden(x_q, nout, 4), idx_rc[nout]);
            end
            nout++;
         end else if (bus.valid_data === 1'b1) begin
            nout++;
         end
      end
      checks++;
      if (nout != 8) begin
         failures++; $display("FAIL ratechg_count got=%0d exp=8", nout);
      end

      // Enable low for two cycles mid-symbol
      do_reset();
      clear_x();
      x_i[0] = gray_lvl(en_i[0]); x_q[0] = gray_lvl(en_q[0]);
      x_i[4] = gray_lvl(en_i[1]); x_q[4] = gray_lvl(en_q[1]);
      rate = 9'd4; ptr = 0; nout = 0;
      for (int c = 0; c < 12; c++) begin
         enable = !(c == 2 || c == 3);
         bus.sym_valid = (ptr < 2);
         bus.sym_i = en_i[ptr % 2]; bus.sym_q = en_q[ptr % 2];
         #1;
         if (bus.sym_valid && bus.sym_ready) ptr++;
         step();
         checks++;
         if (bus.valid_data !== vmask[c]) begin
            failures++; $display("FAIL enable_valid c=%0d got=%b exp=%b", c, bus.valid_data, vmask[c]);
         end
         if (bus.valid_data === 1'b1 && nout < 8) begin
            checks++;
            if (bus.I_filter !== 12'(golden(x_i, nout, 4)) || bus.Q_filter !== 12'(golden(x_q, nout, 4)) ||
                bus.sample_index !== 9'(idx_en[nout])) begin
               failures++;
               $display("FAIL enable_sample n=%0d got i=%0d q=%0d idx=%0d exp i=%0d q=%0d idx=%0d",
                        nout, bus.I_filter, bus.Q_filter, bus.sample_index,
                        golden(x_i, nout, 4), golden(x_q, nout, 4), idx_en[nout]);
            end
            nout++;
         end
      end
      enable = 1'b0;
      bus.sym_valid = 1'b1;
      #1;
      checks++;
      if (bus.sym_ready !== 1'b0) begin
         failures++; $display("FAIL enable_gates_ready got=%b exp=0", bus.sym_ready);
      end
      step();
      step();
      checks++;
      if (bus.valid_data !== 1'b0) begin
         failures++; $display("FAIL enable_no_accept got=%b exp=0", bus.valid_data);
      end
      bus.sym_valid = 1'b0;
      enable = 1'b1;
   endtask

   task automatic test_mid_reset();
      do_reset();
      rate = 9'd8;
      bus.sym_valid = 1'b1; bus.sym_i = 3'b111; bus.sym_q = 3'b001;
      step();
      bus.sym_valid = 1'b0;
      repeat (3) step();
      checks++;
      if (bus.valid_data !== 1'b1 || bus.sample_index !== 9'd2) begin
         failures++; $display("FAIL midrst_pre got v=%b idx=%0d exp v=1 idx=2", bus.valid_data, bus.sample_index);
      end
      step();
      rst = 1'b0;
      bus.sym_valid = 1'b1; bus.sym_i = 3'b101; bus.sym_q = 3'b011;
      step();
      checks++;
      if (bus.valid_data !== 1'b0 || bus.I_filter !== 12'd0 || bus.Q_filter !== 12'd0 ||
          bus.sample_index !== 9'd0 || bus.sym_ready !== 1'b0) begin
         failures++;
         $display("FAIL midrst_cleared got v=%b i=%0d q=%0d idx=%0d rdy=%b exp all 0",
                  bus.valid_data, bus.I_filter, bus.Q_filter, bus.sample_index, bus.sym_ready);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (bus.sym_ready !== 1'b1) begin
         failures++; $display("FAIL midrst_ready got=%b exp=1", bus.sym_ready);
      end
      step();
      bus.sym_valid = 1'b0;
      checks++;
      if (bus.valid_data !== 1'b0) begin
         failures++; $display("FAIL midrst_latency got=%b exp=0", bus.valid_data);
      end
      step();
      checks++;
      if (bus.valid_data !== 1'b1 || bus.sample_index !== 9'd0 || bus.I_filter !== 12'(-2) || bus.Q_filter !== 12'd0) begin
         failures++;
         $display("FAIL midrst_first got v=%b idx=%0d i=%0d q=%0d exp v=1 idx=0 i=-2 q=0",
                  bus.valid_data, bus.sample_index, bus.I_filter, bus.Q_filter);
      end
      step();
      checks++;
      if (bus.valid_data !== 1'b1 || bus.sample_index !== 9'd1 || bus.I_filter !== 12'(-4) || bus.Q_filter !== 12'd1) begin
         failures++;
         $display("FAIL midrst_second got v=%b idx=%0d i=%0d q=%0d exp v=1 idx=1 i=-4 q=1",
                  bus.valid_data, bus.sample_index, bus.I_filter, bus.Q_filter);
      end
   endtask

   initial begin
      rst = 1'b0; enable = 1'b0; rate = '0;
      bus.sym_valid = 1'b0; bus.sym_i = '0; bus.sym_q = '0;
      bus_s.sym_valid = 1'b0; bus_s.sym_i = '0; bus_s.sym_q = '0;
      @(negedge clk);
      test_reset();
      test_impulse();
      test_stream();
      test_saturation();
      test_rate_edges();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
